cam_dvp_tx: RTL
===============

Name: cam_dvp_tx

Overview:
- Camera-side DVP source: serializes a 16-bit RGB565 pixel stream onto an 8-bit pclk-synchronous bus with vsync/href framing, mirroring OV-sensor timing.
- Drives the camera-input path on FPGA-only builds and loopback benches, in place of a physical sensor.
- Pixel data is pulled from an upstream frame source or test-pattern block through a valid/ready handshake.

Parameters:
- H_ACTIVE, 640: pixels per line; the line carries 2*H_ACTIVE bytes. Must be >= 1.
- H_BLANK, 144: href-low pclk cycles after each active line. Must be >= 1.
- V_ACTIVE, 480: active lines per frame. Must be >= 1.
- VSYNC_LINES, 3: line periods with vsync high. Must be >= 1.
- V_BACK, 17: blank line periods after vsync. Must be >= 1.
- V_FRONT, 10: blank line periods after the last active line. Must be >= 1.
- HIGH_FIRST, 0: 0 = byte N is px_data[7:0] and byte N+1 is px_data[15:8]; 1 = reversed.

Ports:
- pclk  in  1  pixel clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  pulse; begins frame generation.
- stop  in  1  pulse; stops after the current frame completes.
- px_data  in  16  RGB565 pixel.
- px_valid  in  1  px_data is valid.
- px_ready  out  1  pixel is consumed this cycle if px_valid=1.
- dout  out  8  DVP data bus (D7..D0).
- vsync  out  1  frame sync, active high.
- href  out  1  line valid, active high.
- busy  out  1  frame generation in progress.
- frame_done  out  1  one-cycle pulse on the last V_FRONT cycle of each frame.
- underflow  out  1  sticky: a pixel was needed while px_valid=0.

Behaviour:
- Reset (asynchronous, active-low, effective immediately, including mid-frame): dout=0, vsync=0, href=0, busy=0, frame_done=0, underflow=0; state=IDLE; all counters 0.
- dout, vsync and href are registered outputs. px_ready is combinational from state and counters.
- LINE = 2*H_ACTIVE + H_BLANK cycles.
- States and dwell times:
  - IDLE -> VS on a cycle where start=1 and stop=0. start=1 with stop=1 in IDLE: stay in IDLE.
  - VS: VSYNC_LINES*LINE cycles, vsync=1, href=0. Then -> VB.
  - VB: V_BACK*LINE cycles, all outputs low. Then -> ACT.
  - ACT: V_ACTIVE lines. Each line is 2*H_ACTIVE cycles with href=1, then H_BLANK cycles with href=0. Then -> VF.
  - VF: V_FRONT*LINE cycles, all outputs low. frame_done=1 on the last VF cycle. Then -> VS if no stop is pending, else -> IDLE.
- Start latency: start sampled at edge N in IDLE gives vsync=1 and busy=1 from edge N.
- busy = 1 in every state except IDLE.
- Handshake:
  - px_ready=1 exactly in the cycle before each even-byte href cycle, i.e. once per pixel, H_ACTIVE times per line.
  - Pixel accepted at that edge: its first byte is on dout during the next cycle and its second byte during the cycle after.
  - px_ready is never asserted outside those cycles, and never in IDLE.
- Underflow: if px_valid=0 while px_ready=1, both bytes of that pixel are driven 0x00 and underflow is set. Framing is unaffected.
  - underflow is cleared only by reset or by an accepted start.
- Stop:
  - stop while busy sets stop_pending. The frame in progress completes fully, then the block goes to IDLE.
  - stop_pending clears on entry to IDLE. stop in IDLE is ignored.
- start while busy is ignored.
- Counters:
  - Pixel counter: clog2(H_ACTIVE)+1 bits.
  - Cycle-in-line counter: clog2(LINE) bits.
  - Line counter: sized for max(VSYNC_LINES, V_BACK, V_ACTIVE, V_FRONT).
  - All counters wrap to 0 at each state or line boundary. No off-by-one: every line period is exactly LINE cycles.
- dout holds 0x00 whenever href=0.

Test Plan:
Common bench parameters: H_ACTIVE=4, H_BLANK=3, V_ACTIVE=2, VSYNC_LINES=1, V_BACK=1, V_FRONT=1, so LINE=11 and a frame is 55 cycles.
- Basic frame: start pulse, px_valid=1, pixels 0x1201, 0x3423, ... -> vsync high for 11 cycles, then 11 idle cycles. Next, href high 8 cycles with bytes 01,12,23,34,..., then low 3 cycles; 2 such lines; 11 idle cycles; frame_done at cycle 55; px_ready pulses 8 times per frame.
- Continuous mode: no stop -> second vsync rises the cycle after frame_done. Frame period is exactly 55 cycles over 3 frames; busy stays 1.
- Stop mid-frame: stop at cycle 20 -> frame completes, frame_done at cycle 55, then busy=0. No further vsync; a start pulse in the same cycle as stop is ignored.
- Underflow: px_valid=0 for the 3rd pixel of line 1 -> bytes 5 and 6 of that line are 0x00 and underflow=1 persists. Framing is unchanged; the next start clears underflow.
- HIGH_FIRST=1: pixel 0xABCD -> dout sequence AB then CD.
- Reset mid-line: rst_n low during href -> href, vsync, dout, busy and px_ready go 0 immediately. After release, the block stays idle until start.

Source files
------------

// File: rtl/cam_dvp_tx.sv
// Camera-side DVP source: serializes 16-bit pixels onto an 8-bit bus with
// vsync/href framing in OV-sensor style timing.
module cam_dvp_tx #(
  parameter int H_ACTIVE    = 640,
  parameter int H_BLANK     = 144,
  parameter int V_ACTIVE    = 480,
  parameter int VSYNC_LINES = 3,
  parameter int V_BACK      = 17,
  parameter int V_FRONT     = 10,
  parameter int HIGH_FIRST  = 0
) (
  input  logic        pclk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic [15:0] px_data,
  input  logic        px_valid,
  output logic        px_ready,
  output logic [7:0]  dout,
  output logic        vsync,
  output logic        href,
  output logic        busy,
  output logic        frame_done,
  output logic        underflow
);

  localparam int LINE  = 2*H_ACTIVE + H_BLANK;
  localparam int CW    = $clog2(LINE);
  localparam int VM1   = (VSYNC_LINES > V_BACK) ? VSYNC_LINES : V_BACK;
  localparam int VM2   = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
  localparam int VMAX  = (VM1 > VM2) ? VM1 : VM2;
  localparam int LW    = (VMAX > 1) ? $clog2(VMAX) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(LINE-1);
  localparam logic [CW-1:0] C_HEND = CW'(2*H_ACTIVE);

  typedef enum logic [2:0] {S_IDLE, S_VS, S_VB, S_ACT, S_VF} state_t;

  state_t          r_state, w_ns;
  logic [CW-1:0]   r_c, w_nc;
  logic [LW-1:0]   r_l, w_nl;
  logic            r_stop_pend, r_vsync, r_href, r_busy, r_fdone, r_uf;
  logic [7:0]      r_dout, r_second;
  logic            w_c_last, w_l_last, w_ready, w_href_n, w_start_ok;
  logic [15:0]     w_pix;
  logic [7:0]      w_first, w_second;

  always_comb begin
    w_c_last = (r_c == C_LAST);
    w_l_last = 1'b0;
    case (r_state)
      S_VS:    w_l_last = (r_l == LW'(VSYNC_LINES-1));
      S_VB:    w_l_last = (r_l == LW'(V_BACK-1));
      S_ACT:   w_l_last = (r_l == LW'(V_ACTIVE-1));
      S_VF:    w_l_last = (r_l == LW'(V_FRONT-1));
      default: w_l_last = 1'b0;
    endcase
  end

  // Ready one cycle ahead of every even-byte href cycle: last VB cycle,
  // end of a non-final active line, or an odd byte that is not the last one.
  assign w_ready = ((r_state == S_VB) && w_c_last && w_l_last) ||
                   ((r_state == S_ACT) &&
                    ((w_c_last && !w_l_last) ||
                     (r_c[0] && (r_c < CW'(2*H_ACTIVE-1)))));
  assign px_ready = w_ready;

  assign w_start_ok = (r_state == S_IDLE) && start && !stop;

  always_comb begin
    w_ns = r_state;
    w_nc = r_c;
    w_nl = r_l;
    if (r_state == S_IDLE) begin
      if (w_start_ok) begin
        w_ns = S_VS;
        w_nc = '0;
        w_nl = '0;
      end
    end else if (w_c_last) begin
      w_nc = '0;
      if (w_l_last) begin
        w_nl = '0;
        case (r_state)
          S_VS:    w_ns = S_VB;
          S_VB:    w_ns = S_ACT;
          S_ACT:   w_ns = S_VF;
          S_VF:    w_ns = (r_stop_pend || stop) ? S_IDLE : S_VS;
          default: w_ns = S_IDLE;
        endcase
      end else begin
        w_nl = r_l + LW'(1);
      end
    end else begin
      w_nc = r_c + CW'(1);
    end
  end

  assign w_href_n = (w_ns == S_ACT) && (w_nc < C_HEND);
  assign w_pix    = px_valid ? px_data : 16'h0000;
  assign w_first  = (HIGH_FIRST != 0) ? w_pix[15:8] : w_pix[7:0];
  assign w_second = (HIGH_FIRST != 0) ? w_pix[7:0]  : w_pix[15:8];

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_c         <= '0;
      r_l         <= '0;
      r_stop_pend <= 1'b0;
      r_vsync     <= 1'b0;
      r_href      <= 1'b0;
      r_busy      <= 1'b0;
      r_fdone     <= 1'b0;
      r_uf        <= 1'b0;
      r_dout      <= '0;
      r_second    <= '0;
    end else begin
      r_state <= w_ns;
      r_c     <= w_nc;
      r_l     <= w_nl;
      r_vsync <= (w_ns == S_VS);
      r_href  <= w_href_n;
      r_busy  <= (w_ns != S_IDLE);
      r_fdone <= (w_ns == S_VF) && (w_nl == LW'(V_FRONT-1)) && (w_nc == C_LAST);

      if (!w_href_n)    r_dout <= '0;
      else if (!w_nc[0]) r_dout <= w_first;
      else              r_dout <= r_second;

      if (w_ready) r_second <= w_second;

      if (w_ns == S_IDLE)                      r_stop_pend <= 1'b0;
      else if ((r_state != S_IDLE) && stop)    r_stop_pend <= 1'b1;

      if (w_start_ok)                r_uf <= 1'b0;
      else if (w_ready && !px_valid) r_uf <= 1'b1;
    end
  end

  assign dout       = r_dout;
  assign vsync      = r_vsync;
  assign href       = r_href;
  assign busy       = r_busy;
  assign frame_done = r_fdone;
  assign underflow  = r_uf;

endmodule
